// File: rtl/mips_defs.sv
// Shared definitions for the EX-stage multiply/divide unit.
package mips_defs;

  localparam int unsigned DWIDTH = 32;
  localparam int unsigned CNT_W  = 5;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // True for every funct that touches HI/LO.
  function automatic logic is_hilo(input logic [5:0] f);
    return (f inside {[F_MFHI:F_MTLO]}) || (f inside {[F_MULT:F_DIVU]});
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider with sign fixup.
module muldiv_iter
  import mips_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              fix_i,
  input  logic              is_div_i,
  input  logic              is_signed_i,
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  output logic              last_o,
  output logic [DWIDTH-1:0] hi_o,
  output logic [DWIDTH-1:0] lo_o
);

  localparam int unsigned AW = 2 * DWIDTH;

  logic [AW-1:0]     acc_q, acc_d;
  logic [DWIDTH-1:0] mag_b_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              div_q, neg_q, rneg_q, divz_q;

  logic              sa, sb;
  logic [DWIDTH-1:0] mag_a, mag_b;
  logic [DWIDTH:0]   add_s, rem_sh;
  logic [DWIDTH-1:0] diff;
  logic              ge;

  assign sa     = is_signed_i & a_i[DWIDTH-1];
  assign sb     = is_signed_i & b_i[DWIDTH-1];
  assign mag_a  = sa ? (~a_i) + DWIDTH'(1) : a_i;
  assign mag_b  = sb ? (~b_i) + DWIDTH'(1) : b_i;
  assign last_o = (cnt_q == '0);
  assign hi_o   = acc_q[AW-1:DWIDTH];
  assign lo_o   = acc_q[DWIDTH-1:0];

  // Next accumulator: load, one multiply/divide step, or sign fixup.
  always_comb begin
    add_s  = {1'b0, acc_q[AW-1:DWIDTH]} + {1'b0, mag_b_q};
    rem_sh = acc_q[AW-1:DWIDTH-1];
    ge     = (rem_sh >= {1'b0, mag_b_q});
    diff   = rem_sh[DWIDTH-1:0] - mag_b_q;
    acc_d  = acc_q;
    if (start_i) begin
      acc_d = {DWIDTH'(0), mag_a};
    end else if (step_i) begin
      if (div_q)         acc_d = {(ge ? diff : rem_sh[DWIDTH-1:0]), acc_q[DWIDTH-2:0], ge};
      else if (acc_q[0]) acc_d = {add_s, acc_q[DWIDTH-1:1]};
      else               acc_d = {1'b0, acc_q[AW-1:1]};
    end else if (fix_i) begin
      if (!div_q) begin
        if (neg_q) acc_d = AW'(0) - acc_q;
      end else begin
        // Divide by zero leaves LO all ones; the remainder is the dividend.
        acc_d[DWIDTH-1:0]  = divz_q ? '1
                           : (neg_q ? DWIDTH'(0) - acc_q[DWIDTH-1:0] : acc_q[DWIDTH-1:0]);
        acc_d[AW-1:DWIDTH] = rneg_q ? DWIDTH'(0) - acc_q[AW-1:DWIDTH] : acc_q[AW-1:DWIDTH];
      end
    end
  end

  // Operand magnitude, result signs and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mag_b_q <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (start_i) begin
        mag_b_q <= mag_b;
        cnt_q   <= CNT_W'(DWIDTH - 1);
        div_q   <= is_div_i;
        neg_q   <= sa ^ sb;
        rneg_q  <= sa;
        divz_q  <= (b_i == '0);
      end else if (step_i) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO register file with iterative multiply/divide control.
module ex_muldiv
  import mips_defs::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rtype,
  input  logic [5:0]        funct,
  input  logic              flush,
  input  logic [DWIDTH-1:0] srca,
  input  logic [DWIDTH-1:0] srcb,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] hiout,
  output logic [DWIDTH-1:0] loout,
  output logic [DWIDTH-1:0] mfdata
);

  state_e            state_q;
  logic              fix_q, busy_q, done_q;
  logic [DWIDTH-1:0] hi_q, lo_q, it_hi, it_lo;
  logic              hilo_op, accept, is_mul, is_div, start, step, fix, last;

  assign hilo_op = rtype & is_hilo(funct);
  assign accept  = (state_q == ST_IDLE) & hilo_op & ~flush;
  assign is_mul  = (funct == F_MULT) | (funct == F_MULTU);
  assign is_div  = (funct == F_DIV)  | (funct == F_DIVU);
  assign start   = accept & (is_mul | is_div);
  assign step    = (state_q == ST_MUL) | (state_q == ST_DIV);
  assign fix     = (state_q == ST_FIX) & ~fix_q;
  assign stall   = busy_q & hilo_op & ~flush;
  assign busy    = busy_q;
  assign done    = done_q;
  assign hiout   = hi_q;
  assign loout   = lo_q;

  muldiv_iter u_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .step_i      (step),
    .fix_i       (fix),
    .is_div_i    (funct[1]),
    .is_signed_i (~funct[0]),
    .a_i         (srca),
    .b_i         (srcb),
    .last_o      (last),
    .hi_o        (it_hi),
    .lo_o        (it_lo)
  );

  // MFHI/MFLO read port.
  always_comb begin
    mfdata = '0;
    if (rtype && funct == F_MFHI)      mfdata = hi_q;
    else if (rtype && funct == F_MFLO) mfdata = lo_q;
  end

  // Control FSM and HI/LO registers; FIX spends one cycle negating, one writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fix_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (funct == F_MTHI) hi_q <= srca;
            if (funct == F_MTLO) lo_q <= srca;
            if (is_mul) begin
              state_q <= ST_MUL;
              busy_q  <= 1'b1;
            end
            if (is_div) begin
              state_q <= ST_DIV;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (last) begin
            state_q <= ST_FIX;
            fix_q   <= 1'b0;
          end
        end
        default: begin
          if (!fix_q) begin
            fix_q <= 1'b1;
          end else begin
            hi_q    <= it_hi;
            lo_q    <= it_lo;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            fix_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rtype;
  logic [5:0]  funct;
  logic        flush;
  logic [31:0] srca, srcb;
  logic        stall, busy, done;
  logic [31:0] hiout, loout, mfdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.DWIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rtype  (rtype),
    .funct  (funct),
    .flush  (flush),
    .srca   (srca),
    .srcb   (srcb),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .hiout  (hiout),
    .loout  (loout),
    .mfdata (mfdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Issue one mul/div, check latency, result and handshake.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(negedge clk);
    rtype = 1'b1; funct = f; srca = a; srcb = b;
    @(negedge clk);
    rtype = 1'b0; funct = '0;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(n);
    check_eq({tag, "_lat"}, 64'(n), 64'd34);
    check_eq({tag, "_hi"}, 64'(hiout), 64'(ehi));
    check_eq({tag, "_lo"}, 64'(loout), 64'(elo));
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int dcount;
    rst_n = 1'b0; rtype = 1'b0; funct = '0; flush = 1'b0; srca = '0; srcb = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hiout), 64'd0);
    check_eq("rst_lo", 64'(loout), 64'd0);
    rst_n = 1'b1;

    // MTHI / MTLO with combinational readback.
    @(negedge clk);
    rtype = 1'b1; funct = 6'h11; srca = 32'h1234;
    @(negedge clk);
    check_eq("mthi", 64'(hiout), 64'h1234);
    funct = 6'h10; #1;
    check_eq("mfhi", 64'(mfdata), 64'h1234);
    @(negedge clk);
    funct = 6'h13; srca = 32'h5678;
    @(negedge clk);
    check_eq("mtlo", 64'(loout), 64'h5678);
    funct = 6'h12; #1;
    check_eq("mflo", 64'(mfdata), 64'h5678);
    @(negedge clk);
    rtype = 1'b0; funct = '0; #1;
    check_eq("mf_none", 64'(mfdata), 64'd0);

    run_op("mult_neg", 6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_min", 6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("div_neg", 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_z", 6'h1B, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    run_op("div_z_neg", 6'h1A, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_norm", 6'h1B, 32'd1000, 32'd7, 32'd6, 32'd142);

    // MULT then dependent MFLO: stalled until the result lands.
    @(negedge clk);
    rtype = 1'b1; funct = 6'h18; srca = 32'd6; srcb = 32'd7;
    @(negedge clk);
    funct = 6'h12;
    n = 0;
    while (stall && n < 60) begin
      n++;
      @(negedge clk);
    end
    check_eq("mflo_stall_cycles", 64'(n), 64'd34);
    check_eq("mflo_done", 64'(done), 64'd1);
    check_eq("mflo_data", 64'(mfdata), 64'd42);
    @(negedge clk);
    rtype = 1'b0; funct = '0;

    // Flush and non-HI/LO ops never stall.
    @(negedge clk);
    rtype = 1'b1; funct = 6'h18; srca = 32'd2; srcb = 32'd3;
    @(negedge clk);
    funct = 6'h12; flush = 1'b1; #1;
    check_eq("flush_stall", 64'(stall), 64'd0);
    flush = 1'b0; #1;
    check_eq("busy_stall", 64'(stall), 64'd1);
    funct = 6'h20; #1;
    check_eq("add_stall", 64'(stall), 64'd0);
    rtype = 1'b0; funct = '0;
    wait_done(n);
    check_eq("flush_op_lo", 64'(loout), 64'd6);
    @(negedge clk);
    rtype = 1'b1; funct = 6'h11; srca = 32'hDEAD; flush = 1'b1;
    @(negedge clk);
    check_eq("flush_mthi", 64'(hiout), 64'd0);
    rtype = 1'b0; funct = '0; flush = 1'b0;

    // MTLO while busy: held, applied after the multiply writes back.
    @(negedge clk);
    rtype = 1'b1; funct = 6'h19; srca = 32'd3; srcb = 32'd5;
    @(negedge clk);
    funct = 6'h13; srca = 32'hABCD; #1;
    check_eq("mtlo_stall", 64'(stall), 64'd1);
    wait_done(n);
    check_eq("mtlo_mul_lo", 64'(loout), 64'd15);
    check_eq("mtlo_unstall", 64'(stall), 64'd0);
    @(negedge clk);
    check_eq("mtlo_late", 64'(loout), 64'hABCD);
    rtype = 1'b0; funct = '0;

    // Reset in the middle of a divide.
    @(negedge clk);
    rtype = 1'b1; funct = 6'h1B; srca = 32'd1000; srcb = 32'd3;
    @(negedge clk);
    funct = 6'h10;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; #1;
    check_eq("rstmid_busy", 64'(busy), 64'd0);
    check_eq("rstmid_stall", 64'(stall), 64'd0);
    check_eq("rstmid_done", 64'(done), 64'd0);
    check_eq("rstmid_hilo", {32'(hiout), 32'(loout)}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rtype = 1'b0; funct = '0;
    dcount = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check_eq("rstmid_no_done", 64'(dcount), 64'd0);
    check_eq("rstmid_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
